// File: rtl/ysyx_23060201_lsu_if.sv
// Bundle of the LSU's EXU request, WBU response and MEM read/write ports.
// The master modport is the environment side; the LSU uses the slave modport.
interface ysyx_23060201_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [7:0]  mem_rmask;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_wdata;

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata,
    output resp_ready,
    output mem_rdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_ren, mem_raddr, mem_rmask,
    input  mem_wen, mem_waddr, mem_wmask, mem_wdata
  );

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata,
    input  resp_ready,
    input  mem_rdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_ren, mem_raddr, mem_rmask,
    output mem_wen, mem_waddr, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit between EXU and MEM: one access in flight, lane masks,
// store-data lane shift, load extraction/extension, registered WBU response.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | mem_ren asserted for one cycle
// LWAIT | read data arrives; extract and extend it
// STORE | mem_wen asserted for one cycle
// RESP  | response held until WBU takes it
module ysyx_23060201_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ysyx_23060201_lsu_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_LWAIT = 3'd2,
    S_STORE = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              funct3_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;

  logic                    accept;
  logic                    req_err;
  logic [1:0]              off;
  logic [3:0]              lane_mask;
  logic [DATA_WIDTH-1:0]   load_shifted;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign accept = bus.req_valid && (state == S_IDLE);
  assign off    = addr_q[1:0];

  // Legality depends on the live request so the error is known at accept.
  always_comb begin
    req_err = 1'b1;
    if (bus.req_wen) begin
      case (bus.req_funct3)
        3'd0:    req_err = 1'b0;
        3'd1:    req_err = bus.req_addr[0];
        3'd2:    req_err = |bus.req_addr[1:0];
        default: req_err = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3)
        3'd0, 3'd4: req_err = 1'b0;
        3'd1, 3'd5: req_err = bus.req_addr[0];
        3'd2:       req_err = |bus.req_addr[1:0];
        default:    req_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    lane_mask = 4'b1111;
    case (funct3_q[1:0])
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_comb begin
    load_shifted = bus.mem_rdata >> {off, 3'b000};
    load_ext     = bus.mem_rdata;
    case (funct3_q)
      3'd0: load_ext = {{(DATA_WIDTH-8){load_shifted[7]}},   load_shifted[7:0]};
      3'd1: load_ext = {{(DATA_WIDTH-16){load_shifted[15]}}, load_shifted[15:0]};
      3'd4: load_ext = {{(DATA_WIDTH-8){1'b0}},              load_shifted[7:0]};
      3'd5: load_ext = {{(DATA_WIDTH-16){1'b0}},             load_shifted[15:0]};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)          state_nxt = S_RESP;
          else if (bus.req_wen) state_nxt = S_STORE;
          else                  state_nxt = S_LOAD;
        end
      end
      S_LOAD:  state_nxt = S_LWAIT;
      S_LWAIT: state_nxt = S_RESP;
      S_STORE: state_nxt = S_RESP;
      S_RESP:  if (bus.resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // rdata_q is cleared at accept so stores and errors answer with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      addr_q   <= bus.req_addr;
      funct3_q <= bus.req_funct3;
      wdata_q  <= bus.req_wdata;
      rdata_q  <= '0;
      err_q    <= req_err;
    end else if (state == S_LWAIT) begin
      rdata_q  <= load_ext;
    end
  end

  assign bus.req_ready  = (state == S_IDLE);

  assign bus.mem_ren    = (state == S_LOAD);
  assign bus.mem_raddr  = bus.mem_ren ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_rmask  = bus.mem_ren ? {4'b0000, lane_mask} : 8'h00;

  assign bus.mem_wen    = (state == S_STORE);
  assign bus.mem_waddr  = bus.mem_wen ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign bus.mem_wmask  = bus.mem_wen ? {4'b0000, lane_mask} : 8'h00;
  assign bus.mem_wdata  = bus.mem_wen ? (wdata_q << {off, 3'b000}) : '0;

  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = bus.resp_valid ? rdata_q : '0;
  assign bus.resp_err   = bus.resp_valid && err_q;

endmodule
